lc3_program_loader: RTL

Upstream feeder for the LC-3 datapath: accepts a stream of 16-bit instruction words over a valid/ready handshake and writes them to consecutive memory locations through the memory special-input path (`MARSpcIn`/`MDRSpcIn`). When the last word is written, it presents the program entry point for loading into the PC and releases the control state machine via `run`. This moves the hard-coded preload sequence out of the control FSM and into a reusable stage.

---
 rtl/lc3_program_loader.sv | 231 +++++++++++++++++++++++
 1 files changed

// File: rtl/lc3_program_loader.sv
//==============================================================================
// Module      : lc3_program_loader
// Description : Accepts a valid/ready stream of 16-bit instruction words and
//               writes them to consecutive memory locations through the
//               MARSpcIn/MDRSpcIn special-input path. When the last word has
//               been written it presents the entry point (pc_init/ldPCInit)
//               and then releases the control FSM through run.
//               Optional macro LC3_LOADER_VERIFY_EN adds a read-back check of
//               every written word (READ/CHECK states and the mem_rdata port).
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module lc3_program_loader #(
   parameter int MAX_WORDS = 256
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic [15:0] load_base,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [15:0] in_data,
   input  logic        in_last,
   output logic [15:0] MARSpcIn,
   output logic [15:0] MDRSpcIn,
   output logic        ldMARSpcIn,
   output logic        ldMAR,
   output logic        ldMDR,
   output logic [1:0]  selMDR,
   output logic        memWE,
   output logic [15:0] pc_init,
   output logic        ldPCInit,
   output logic        run,
   output logic        busy,
   output logic        error,
`ifdef LC3_LOADER_VERIFY_EN
   input  logic [15:0] mem_rdata,
`endif
   output logic [8:0]  word_count
);

   localparam logic [8:0] C_MAX_WORDS = 9'(MAX_WORDS);

`ifdef LC3_LOADER_VERIFY_EN
   typedef enum logic [3:0] {
      S_IDLE, S_ACCEPT, S_DRIVE, S_WRITE, S_FINISH, S_DONE, S_ERROR, S_READ, S_CHECK
   } state_t;
`else
   typedef enum logic [2:0] {
      S_IDLE, S_ACCEPT, S_DRIVE, S_WRITE, S_FINISH, S_DONE, S_ERROR
   } state_t;
`endif

   state_t      state_q, state_d;
   logic [15:0] addr_q, addr_d;
   logic [15:0] base_q, base_d;
   logic        last_q, last_d;
   logic [8:0]  count_q, count_d;
   logic [8:0]  count_inc;

   // Registered output copies; every port is driven straight from a flop.
   logic [15:0] mar_q, mar_d;
   logic [15:0] mdr_q, mdr_d;
   logic [15:0] pc_init_q, pc_init_d;
   logic        in_ready_q, in_ready_d;
   logic        ld_strobe_q, ld_strobe_d;
   logic        ld_mdr_q, ld_mdr_d;
   logic [1:0]  sel_mdr_q, sel_mdr_d;
   logic        mem_we_q, mem_we_d;
   logic        ld_pc_q, ld_pc_d;
   logic        run_q, run_d;
   logic        busy_q, busy_d;
   logic        error_q, error_d;

   // After a word is committed: finish on last, error on reaching the limit.
   function automatic state_t next_after_word(input logic last, input logic [8:0] cnt);
      if (last)
         return S_FINISH;
      else if (cnt == C_MAX_WORDS)
         return S_ERROR;
      else
         return S_ACCEPT;
   endfunction

   assign count_inc = count_q + 9'd1;

   // Next-state logic plus the next value of every registered output.
   always_comb begin
      state_d   = state_q;
      addr_d    = addr_q;
      base_d    = base_q;
      last_d    = last_q;
      count_d   = count_q;
      mar_d     = mar_q;
      mdr_d     = mdr_q;
      pc_init_d = pc_init_q;

      unique case (state_q)
         S_IDLE, S_DONE, S_ERROR: begin
            if (start) begin
               addr_d  = load_base;
               base_d  = load_base;
               count_d = 9'd0;
               state_d = S_ACCEPT;
            end
         end
         S_ACCEPT: begin
            // The word is captured directly into the MDRSpcIn register, which
            // also serves as the latched copy for the rest of the word cycle.
            if (in_valid && in_ready_q) begin
               mdr_d   = in_data;
               mar_d   = addr_q;
               last_d  = in_last;
               state_d = S_DRIVE;
            end
         end
         S_DRIVE: begin
            state_d = S_WRITE;
         end
         S_WRITE: begin
            // Address wraps naturally at 16 bits; a wrap is not an error.
            addr_d  = addr_q + 16'd1;
            count_d = count_inc;
`ifdef LC3_LOADER_VERIFY_EN
            state_d = S_READ;
`else
            state_d = next_after_word(last_q, count_inc);
`endif
         end
`ifdef LC3_LOADER_VERIFY_EN
         S_READ: begin
            state_d = S_CHECK;
         end
         S_CHECK: begin
            // count_q already holds the incremented value from WRITE.
            if (mem_rdata != mdr_q)
               state_d = S_ERROR;
            else
               state_d = next_after_word(last_q, count_q);
         end
`endif
         S_FINISH: begin
            state_d = S_DONE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      if (state_d == S_FINISH)
         pc_init_d = base_q;

      // Outputs are a function of the state being entered, so they are valid
      // for the whole cycle spent in that state.
      in_ready_d  = (state_d == S_ACCEPT);
      ld_strobe_d = (state_d == S_DRIVE);
      ld_mdr_d    = (state_d == S_DRIVE);
      sel_mdr_d   = (state_d == S_DRIVE) ? 2'b11 : 2'b00;
`ifdef LC3_LOADER_VERIFY_EN
      if (state_d == S_READ) begin
         ld_mdr_d  = 1'b1;
         sel_mdr_d = 2'b01;
      end
`endif
      mem_we_d = (state_d == S_WRITE);
      ld_pc_d  = (state_d == S_FINISH);
      run_d    = (state_d == S_DONE);
      error_d  = (state_d == S_ERROR);
      busy_d   = !((state_d == S_IDLE) || (state_d == S_DONE) || (state_d == S_ERROR));
   end

   // State and output registers; reset clears strobes and run immediately.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q     <= S_IDLE;
         addr_q      <= 16'd0;
         base_q      <= 16'd0;
         last_q      <= 1'b0;
         count_q     <= 9'd0;
         mar_q       <= 16'd0;
         mdr_q       <= 16'd0;
         pc_init_q   <= 16'd0;
         in_ready_q  <= 1'b0;
         ld_strobe_q <= 1'b0;
         ld_mdr_q    <= 1'b0;
         sel_mdr_q   <= 2'b00;
         mem_we_q    <= 1'b0;
         ld_pc_q     <= 1'b0;
         run_q       <= 1'b0;
         busy_q      <= 1'b0;
         error_q     <= 1'b0;
      end else begin
         state_q     <= state_d;
         addr_q      <= addr_d;
         base_q      <= base_d;
         last_q      <= last_d;
         count_q     <= count_d;
         mar_q       <= mar_d;
         mdr_q       <= mdr_d;
         pc_init_q   <= pc_init_d;
         in_ready_q  <= in_ready_d;
         ld_strobe_q <= ld_strobe_d;
         ld_mdr_q    <= ld_mdr_d;
         sel_mdr_q   <= sel_mdr_d;
         mem_we_q    <= mem_we_d;
         ld_pc_q     <= ld_pc_d;
         run_q       <= run_d;
         busy_q      <= busy_d;
         error_q     <= error_d;
      end
   end

   assign in_ready   = in_ready_q;
   assign MARSpcIn   = mar_q;
   assign MDRSpcIn   = mdr_q;
   assign ldMARSpcIn = ld_strobe_q;
   assign ldMAR      = ld_strobe_q;
   assign ldMDR      = ld_mdr_q;
   assign selMDR     = sel_mdr_q;
   assign memWE      = mem_we_q;
   assign pc_init    = pc_init_q;
   assign ldPCInit   = ld_pc_q;
   assign run        = run_q;
   assign busy       = busy_q;
   assign error      = error_q;
   assign word_count = count_q;

endmodule

`default_nettype wire
